// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W      = 5;
  localparam int DEF_MUL_LATENCY = 4;
  localparam int DEF_DIV_LATENCY = 32;
  localparam int DEF_CNT_W       = 6;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/hazard_stall_ctrl_md_seq.sv
// Mult/div sequencer: tracks how long the multi-cycle unit stays busy after a start pulse.
//  state   | meaning
//  MD_IDLE | unit free, waiting for a start pulse
//  MD_BUSY | unit computing, counter runs down to the last busy cycle
module md_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_LATENCY = DEF_MUL_LATENCY,
  parameter int DIV_LATENCY = DEF_DIV_LATENCY,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  input  logic i_is_div,
  output logic o_busy,
  output logic o_done
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LATENCY - 1);

  md_state_e        r_state;
  md_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      MD_IDLE: begin
        if (i_start) begin
          w_state_nxt = MD_BUSY;
          w_cnt_nxt   = i_is_div ? DIV_LOAD : MUL_LOAD;
        end
      end
      MD_BUSY: begin
        if (r_cnt == '0) w_state_nxt = MD_IDLE;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      default: w_state_nxt = MD_IDLE;
    endcase
  end

  assign o_busy = (r_state == MD_BUSY);
  assign o_done = o_busy && (r_cnt == '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall/flush controller: load-use and mult/div interlocks, branch flush, stall counter.
module hazard_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_LATENCY = DEF_MUL_LATENCY,
  parameter int DIV_LATENCY = DEF_DIV_LATENCY,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  id_is_md,
  input  logic                  id_is_div,
  input  logic                  id_reads_hilo,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  branch_taken,
  input  logic                  perf_clr,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  md_start,
  output logic                  md_busy,
  output logic                  md_done,
  output logic [15:0]           stall_cycles
);

  logic        w_load_use;
  logic        w_md_hazard;
  logic        w_stall;
  logic [15:0] r_stall_cycles;

  // $0 is hardwired zero, so a load targeting it never creates a dependency
  assign w_load_use = ex_mem_read && (ex_rd != '0) &&
                      ((id_uses_rs && (id_rs == ex_rd)) ||
                       (id_uses_rt && (id_rt == ex_rd)));
  assign w_md_hazard = md_busy && (id_is_md || id_reads_hilo);
  assign w_stall     = w_load_use || w_md_hazard;

  assign pc_write     = branch_taken || !w_stall;
  assign if_id_write  = branch_taken || !w_stall;
  assign if_id_flush  = branch_taken;
  assign id_ex_bubble = branch_taken || w_stall;
  assign md_start     = id_is_md && !w_stall && !branch_taken;

  md_seq #(
    .MUL_LATENCY (MUL_LATENCY),
    .DIV_LATENCY (DIV_LATENCY),
    .CNT_W       (CNT_W)
  ) u_md_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (md_start),
    .i_is_div (id_is_div),
    .o_busy   (md_busy),
    .o_done   (md_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
    end else if (perf_clr) begin
      r_stall_cycles <= '0;
    end else if (w_stall && !branch_taken && (r_stall_cycles != 16'hFFFF)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Central hazard, stall and flush controller for the 5-stage MIPS pipeline. Each cycle it decides whether the PC and IF/ID register advance, whether a bubble enters ID/EX, and whether IF/ID is flushed. It also sequences the multi-cycle multiply/divide unit: it issues the start pulse, tracks busy time and holds dependent HI/LO instructions in ID. It sits beside the ID stage and drives the pipeline-register enables.

## Interface

Parameters:
- MUL_LATENCY, 4, cycles the mult unit is busy after start (must be ≥1)
- DIV_LATENCY, 32, cycles the div unit is busy after start (must be ≥1)
- CNT_W, 6, width of busy counter (must hold max latency − 1)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_rs, id_rt  in  5  source register numbers of the instruction in ID
- id_uses_rs, id_uses_rt  in  1  ID instruction actually reads rs / rt
- id_is_md  in  1  ID instruction is mult/multu/div/divu
- id_is_div  in  1  qualifies id_is_md: 1 = divide, 0 = multiply
- id_reads_hilo  in  1  ID instruction is mfhi/mflo
- ex_mem_read  in  1  EX instruction is a load
- ex_rd  in  5  destination register of EX instruction
- branch_taken  in  1  branch/jump redirect resolved in EX this cycle
- perf_clr  in  1  synchronous clear of stall counter
- pc_write  out  1  PC enable
- if_id_write  out  1  IF/ID enable
- if_id_flush  out  1  zero IF/ID on next edge
- id_ex_bubble  out  1  load NOP into ID/EX on next edge
- md_start  out  1  one-cycle start pulse to mult/div unit
- md_busy  out  1  mult/div unit is computing
- md_done  out  1  last busy cycle
- stall_cycles  out  16  saturating count of stall cycles

## Operation

- load_use = ex_mem_read & ex_rd≠0 & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
- md_hazard = md_busy & (id_is_md | id_reads_hilo).
- stall = load_use | md_hazard. Both hazards together still give one stall, not two.
- Normal (no stall, no branch): pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0.
- stall & !branch_taken: pc_write=0, if_id_write=0, id_ex_bubble=1.
- branch_taken has priority over stall: pc_write=1, if_id_flush=1, id_ex_bubble=1, md_start=0.
- md_start = id_is_md & !stall & !branch_taken.
- Mult/div FSM, states IDLE and BUSY:
  - IDLE→BUSY on md_start. cnt loads (id_is_div ? DIV_LATENCY : MUL_LATENCY) − 1.
  - In BUSY, cnt decrements each cycle.
  - BUSY→IDLE on the cycle after cnt==0.
- md_busy = (state==BUSY). md_done = BUSY & cnt==0.
- stall_cycles increments on each cycle with stall=1 & !branch_taken and saturates at 0xFFFF. perf_clr wins over increment.

## Timing

- Hazard and control outputs are combinational from inputs and state, with zero latency. State, cnt and stall_cycles are registered.
- md_start in cycle T gives md_busy=1 in cycles T+1 … T+LAT, with md_done in T+LAT. A dependent mfhi/mult held in ID issues in T+LAT+1.
- A load-use stall lasts exactly 1 cycle, because the load moves to MEM and the hazard clears.
- Reset values: state IDLE, cnt 0, stall_cycles 0, md_busy 0, md_done 0, md_start 0.
- Reset asserted mid-BUSY forces IDLE immediately and asynchronously, so md_busy drops without waiting for an edge.
- Register $0 never causes a load-use stall.
- A branch_taken during BUSY does not abort the mult/div operation; only new issue is suppressed.

## Structure

- Shared package pipe_ctrl_pkg holds:
  - FSM state encoding constants (MD_IDLE, MD_BUSY)
  - REG_ADDR_W = 5
  - default latency constants
- One sub-module, md_seq, contains the IDLE/BUSY FSM, the down-counter and md_busy/md_done. The top level contains the hazard equations, the output muxing and the perf counter.

## Test plan

- Load-use: ex_mem_read=1, ex_rd=8, id_rs=8, id_uses_rs=1 → one cycle with pc_write=0, if_id_write=0, id_ex_bubble=1, then normal flow. Repeat with ex_rd=0 → no stall.
- Multiply: id_is_md=1, id_is_div=0 at T → md_start=1 at T; md_busy high T+1…T+4; md_done at T+4. mfhi in ID from T+1 → stalled 4 cycles, issues at T+5.
- Back-to-back divide: div issues, then mult in ID → mult stalled 32 cycles; md_start again at T+33.
- Branch vs stall: load_use and branch_taken in the same cycle → pc_write=1, if_id_flush=1, id_ex_bubble=1, stall_cycles unchanged.
- Reset in BUSY: drop rst_n at cnt=10 → md_busy=0 immediately; after release, a new mult starts a clean 4-cycle sequence.
- Perf counter: force a continuous stall for 70000 cycles → stall_cycles=0xFFFF. Pulse perf_clr → 0 next edge.
